// File: rtl/mem_access_controller.sv
// mem_access_controller
//   Sequences LW/SW data accesses between the datapath, a write-back data cache
//   and a fixed-latency main memory. A miss stalls the pipeline, writes back a
//   dirty victim line if needed, refills the line, then releases the stall so
//   the held access completes as a hit.
//
// Parameters:
//   MEM_LATENCY     main-memory cycles per line transfer (>= 1)
//
// Ports:
//   clk             system clock, rising edge
//   rst_b           asynchronous active-low reset
//   load_req        LW in execute stage
//   store_req       SW in execute stage (wins over load_req when both set)
//   hit             cache tag match for current address
//   dirty           indexed victim line dirty bit
//   stall           freeze PC and pipeline registers
//   mem_read_en     main-memory line read active
//   mem_write_en    main-memory victim write-back active
//   cache_fill_en   write refilled line into cache
//   cache_store_en  write store word into cache, set dirty
//
// Optional feature (macro MEM_CTRL_PERF_EN):
//   miss_count      saturating count of IDLE miss cycles
//   writeback_count saturating count of IDLE dirty-miss cycles
module mem_access_controller #(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        load_req,
    input  logic        store_req,
    input  logic        hit,
    input  logic        dirty,
    output logic        stall,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic        cache_fill_en,
    output logic        cache_store_en
`ifdef MEM_CTRL_PERF_EN
    ,
    output logic [31:0] miss_count,
    output logic [31:0] writeback_count
`endif
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CntReload = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StRefill
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic req;
    logic stall_c, mem_read_c, mem_write_c, fill_c, store_c;

    assign req = load_req | store_req;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_c     = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        fill_c      = 1'b0;
        store_c     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (hit) begin
                        store_c = store_req;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = CntReload;
                        state_d = dirty ? StWriteback : StRefill;
                    end
                end
            end
            StWriteback: begin
                stall_c     = 1'b1;
                mem_write_c = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = CntReload;
                    state_d = StRefill;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRefill: begin
                stall_c    = 1'b1;
                mem_read_c = 1'b1;
                if (cnt_q == '0) begin
                    fill_c  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The state register sits in IDLE during reset, but a held request would still
    // decode; gate with rst_b so every output is low while reset is asserted.
    assign stall          = stall_c & rst_b;
    assign mem_read_en    = mem_read_c & rst_b;
    assign mem_write_en   = mem_write_c & rst_b;
    assign cache_fill_en  = fill_c & rst_b;
    assign cache_store_en = store_c & rst_b;

`ifdef MEM_CTRL_PERF_EN
    logic [31:0] miss_q, miss_d;
    logic [31:0] wb_q, wb_d;
    logic        miss_ev;

    assign miss_ev = (state_q == StIdle) & req & ~hit;

    always_comb begin
        miss_d = miss_q;
        wb_d   = wb_q;
        if (miss_ev && (miss_q != 32'hFFFF_FFFF)) begin
            miss_d = miss_q + 32'd1;
        end
        if (miss_ev && dirty && (wb_q != 32'hFFFF_FFFF)) begin
            wb_d = wb_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            miss_q <= miss_d;
            wb_q   <= wb_d;
        end
    end

    assign miss_count      = miss_q;
    assign writeback_count = wb_q;
`endif

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: one instance at MEM_LATENCY=4 and
// one at MEM_LATENCY=1. Inputs change 2 time units after a rising edge and the
// combinational outputs are checked 1 unit later, well away from the edge.
module tb_mem_access_controller;

    logic clk = 1'b0;
    logic rst_b;
    logic load_req, store_req, hit, dirty;
    logic stall, mem_read_en, mem_write_en, cache_fill_en, cache_store_en;

    logic ld1, st1, hit1, dirty1;
    logic stall1, rd1, wr1, fill1, store1;

`ifdef MEM_CTRL_PERF_EN
    logic [31:0] miss_count, writeback_count;
    logic [31:0] miss_count1, writeback_count1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int stall_cycles;

    always #5 clk = ~clk;

    mem_access_controller #(.MEM_LATENCY(4)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .load_req       (load_req),
        .store_req      (store_req),
        .hit            (hit),
        .dirty          (dirty),
        .stall          (stall),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .cache_fill_en  (cache_fill_en),
        .cache_store_en (cache_store_en)
`ifdef MEM_CTRL_PERF_EN
        ,
        .miss_count     (miss_count),
        .writeback_count(writeback_count)
`endif
    );

    mem_access_controller #(.MEM_LATENCY(1)) dut1 (
        .clk            (clk),
        .rst_b          (rst_b),
        .load_req       (ld1),
        .store_req      (st1),
        .hit            (hit1),
        .dirty          (dirty1),
        .stall          (stall1),
        .mem_read_en    (rd1),
        .mem_write_en   (wr1),
        .cache_fill_en  (fill1),
        .cache_store_en (store1)
`ifdef MEM_CTRL_PERF_EN
        ,
        .miss_count     (miss_count1),
        .writeback_count(writeback_count1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected vector order: {stall, mem_read_en, mem_write_en, cache_fill_en, cache_store_en}
    task automatic chk_out(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, stall, mem_read_en, mem_write_en, cache_fill_en, cache_store_en},
            {27'd0, exp});
    endtask

    task automatic chk_out1(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, stall1, rd1, wr1, fill1, store1}, {27'd0, exp});
    endtask

    // Advance to 2 units past the next rising edge (input-drive point).
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic ld, input logic st, input logic h, input logic d);
        load_req  = ld;
        store_req = st;
        hit       = h;
        dirty     = d;
        #1;
    endtask

    initial begin
        rst_b = 1'b0;
        ld1 = 1'b0; st1 = 1'b0; hit1 = 1'b0; dirty1 = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("in_reset_outputs_low", 5'b00000);
        cyc();
        cyc();
        rst_b = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("idle_no_req", 5'b00000);
`ifdef MEM_CTRL_PERF_EN
        chk("reset_miss_count", miss_count, 32'd0);
        chk("reset_wb_count", writeback_count, 32'd0);
`endif

        // Load hit: nothing to do, stays idle.
        cyc(); set_in(1'b1, 1'b0, 1'b1, 1'b1);
        chk_out("load_hit_c0", 5'b00000);
        cyc(); set_in(1'b1, 1'b0, 1'b1, 1'b1);
        chk_out("load_hit_c1", 5'b00000);

        // Store hit: one store-enable cycle, then drop.
        cyc(); set_in(1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("store_hit", 5'b00001);
        cyc(); set_in(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("store_hit_after", 5'b00000);

        // Both requests at once count as a store.
        cyc(); set_in(1'b1, 1'b1, 1'b1, 1'b0);
        chk_out("load_store_hit", 5'b00001);

        // Clean load miss, L=4.
        cyc(); set_in(1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("clean_c0", 5'b10000);
        for (int i = 1; i <= 4; i++) begin
            cyc(); set_in(1'b1, 1'b0, 1'b0, 1'b1); // hit/dirty ignored outside IDLE
            chk_out($sformatf("clean_c%0d", i), (i == 4) ? 5'b11010 : 5'b11000);
        end
        cyc(); set_in(1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("clean_c5_hit", 5'b00000);

        // Dirty store miss, L=4.
        stall_cycles = 0;
        cyc(); set_in(1'b0, 1'b1, 1'b0, 1'b1);
        chk_out("dirty_c0", 5'b10000);
        if (stall) stall_cycles++;
        for (int i = 1; i <= 8; i++) begin
            cyc(); set_in(1'b0, 1'b1, 1'b0, 1'b1);
            if (i <= 4) chk_out($sformatf("dirty_c%0d", i), 5'b10100);
            else if (i < 8) chk_out($sformatf("dirty_c%0d", i), 5'b11000);
            else chk_out("dirty_c8", 5'b11010);
            if (stall) stall_cycles++;
        end
        cyc(); set_in(1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("dirty_c9_store", 5'b00001);
        if (stall) stall_cycles++;
        chk("dirty_stall_total", stall_cycles, 32'd9);
`ifdef MEM_CTRL_PERF_EN
        chk("pre_reset_miss_count", miss_count, 32'd2);
        chk("pre_reset_wb_count", writeback_count, 32'd1);
`endif

        // Reset in the middle of a refill.
        cyc(); set_in(1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("rst_mid_c0", 5'b10000);
        cyc(); set_in(1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("rst_mid_c1", 5'b11000);
        cyc(); set_in(1'b1, 1'b0, 1'b0, 1'b0);
        chk_out("rst_mid_c2", 5'b11000);
        rst_b = 1'b0;
        #1;
        chk_out("rst_mid_async_drop", 5'b00000);
        cyc();
        rst_b = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("after_rst_idle", 5'b00000);
`ifdef MEM_CTRL_PERF_EN
        chk("after_rst_miss_count", miss_count, 32'd0);
        chk("after_rst_wb_count", writeback_count, 32'd0);
`endif
        cyc(); set_in(1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("after_rst_load_hit", 5'b00000);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);

        // MEM_LATENCY=1 dirty store miss on the second instance.
        cyc();
        st1 = 1'b1; hit1 = 1'b0; dirty1 = 1'b1; #1;
        chk_out1("l1_c0", 5'b10000);
        cyc(); #1;
        chk_out1("l1_c1_wb", 5'b10100);
        cyc(); #1;
        chk_out1("l1_c2_refill", 5'b11010);
        cyc();
        hit1 = 1'b1; dirty1 = 1'b0; #1;
        chk_out1("l1_c3_store", 5'b00001);
        cyc();
        st1 = 1'b0; #1;
        chk_out1("l1_idle", 5'b00000);
`ifdef MEM_CTRL_PERF_EN
        chk("l1_miss_count", miss_count1, 32'd1);
        chk("l1_wb_count", writeback_count1, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sequences data-memory accesses for LW/SW between the processor datapath, a write-back data cache, and a fixed-latency main memory.
- On a cache miss it stalls the processor, writes back a dirty victim line if needed, then refills the line.
- Once the line is refilled it releases the stall so the access completes as a hit.
- Sits between the control unit's memory-request decode and the cache/memory arrays; its stall output drives the processor stall (proc) path.

Parameters:
- MEM_LATENCY, 4, main-memory cycles per line transfer (read or write); legal range >= 1
- CNT_W, $clog2(MEM_LATENCY+1), latency counter width (derived, not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- load_req  input  1  LW in execute stage this cycle
- store_req  input  1  SW in execute stage this cycle
- hit  input  1  cache tag match for current address
- dirty  input  1  indexed victim line dirty bit
- stall  output  1  freeze PC and pipeline registers
- mem_read_en  output  1  main-memory line read active
- mem_write_en  output  1  main-memory line write (victim write-back) active
- cache_fill_en  output  1  write refilled line into cache, set valid, clear dirty
- cache_store_en  output  1  write store word into cache, set dirty

Interface decision: one clock (clk); reset is asynchronous and active-low (rst_b).

Behaviour:
- States: IDLE, WRITEBACK, REFILL. State register and counter reset asynchronously when rst_b=0 to IDLE and cnt=0.
- All outputs are combinational from state, cnt and inputs. Every output is 0 while in reset and in IDLE with no request.
- Request evaluation:
  - req = load_req | store_req.
  - load_req and store_req both 1 is treated as store.
  - Requests and hit/dirty are sampled only in IDLE; in WRITEBACK/REFILL they are ignored. The stalled pipeline holds the request stable.
- IDLE, req & hit:
  - stall=0; stay in IDLE.
  - cache_store_en=1 in the same cycle iff store.
  - Load hits need no action.
- IDLE, req & ~hit:
  - stall=1 in the same cycle.
  - cnt <= MEM_LATENCY-1.
  - Next state is WRITEBACK if dirty, else REFILL.
- WRITEBACK:
  - stall=1, mem_write_en=1.
  - If cnt==0: reload cnt <= MEM_LATENCY-1, go to REFILL. Otherwise cnt <= cnt-1.
- REFILL:
  - stall=1, mem_read_en=1.
  - If cnt==0: cache_fill_en=1 in this cycle, go to IDLE. Otherwise cnt <= cnt-1.
- Return to IDLE after refill:
  - The held request is re-evaluated and now hits, so stall=0.
  - A store writes via cache_store_en in that same cycle.
- Stall timing:
  - Clean miss: stall high for exactly MEM_LATENCY+1 cycles.
  - Dirty miss: stall high for exactly 2*MEM_LATENCY+1 cycles.
- MEM_LATENCY=1: WRITEBACK and REFILL each last one cycle; cnt stays 0.
- Invariants:
  - mem_read_en and mem_write_en are never both 1.
  - cache_fill_en and cache_store_en are never both 1.
  - cache_fill_en is asserted only in REFILL.
- Reset mid-operation aborts any transfer: state returns to IDLE and all enables drop immediately (asynchronous). There is no partial-fill recovery; the memory system is reset alongside.

Optional Feature:
- Macro: MEM_CTRL_PERF_EN.
- Defined:
  - Adds outputs miss_count[31:0] and writeback_count[31:0], both reset to 0 by rst_b.
  - miss_count increments on each IDLE req&~hit cycle.
  - writeback_count increments on each IDLE req&~hit&dirty cycle.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load hit, MEM_LATENCY=4: load_req=1, hit=1 -> stall=0 throughout; no memory or cache enables; state stays IDLE.
- Store hit: store_req=1, hit=1 -> cache_store_en=1 for exactly one cycle; stall=0; mem enables 0.
- Clean load miss, L=4:
  - Stimulus: load_req=1, hit=0, dirty=0 at cycle 0; hit is forced to 1 from cycle 5.
  - Response: stall=1 in cycles 0-4; mem_read_en=1 in cycles 1-4; cache_fill_en=1 only in cycle 4; stall=0 in cycle 5.
- Dirty store miss, L=4:
  - Stimulus: store_req=1, hit=0, dirty=1.
  - Response: mem_write_en in cycles 1-4; mem_read_en in cycles 5-8; fill in cycle 8; cycle 9 has stall=0 and cache_store_en=1; total stall is 9 cycles.
- Reset mid-refill: assert rst_b=0 asynchronously in cycle 2 of a refill -> stall, mem_read_en and all enables go 0 immediately; after release, state is IDLE. With MEM_CTRL_PERF_EN defined, counters read 0.
- MEM_LATENCY=1 dirty miss with MEM_CTRL_PERF_EN: WRITEBACK 1 cycle, REFILL 1 cycle, stall 3 cycles; afterwards miss_count=1 and writeback_count=1.
